stage_timing: RTL and testbench
===============================

STAGE_TIMING -- requirements
Module: stage_timing

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; ports in the order below, clock and reset first.
REQ-002 SIM_CLK  input  1  simulation clock; all state changes on rising edge.
REQ-003 SIM_RST  input  1  reset, asynchronous, active-high.
REQ-004 PHS_EN  input  1  timepulse advance strobe; one SIM_CLK cycle wide per timepulse.
REQ-005 MSTOP  input  1  monitor stop; holds the sequencer at T12.
REQ-006 GOJAM  input  1  restart; synchronous clear of stage state.
REQ-007 ST1REQ  input  1  request stage bit 1 for the next memory cycle time (MCT).
REQ-008 ST2REQ  input  1  request stage bit 2 for the next MCT.
REQ-009 T01_n  output  1  low while timepulse 1 is active.
REQ-010 T02  output  1  high while timepulse 2 is active.
REQ-011 T12_n  output  1  low while timepulse 12 is active.
REQ-012 TP  output  4  current timepulse number, 1..12.
REQ-013 ST0_n  output  1  low when stage = 0.
REQ-014 ST1_n  output  1  low when stage = 1.
REQ-015 STD2  output  1  high when stage = 2.
REQ-016 ST3_n  output  1  low when stage = 3.
REQ-017 MCTEND  output  1  one-cycle pulse on the cycle an MCT boundary transfer occurs.

Function
REQ-018 TP SHALL take only the values 1..12; values 0 and 13..15 are unreachable.
REQ-019 On a PHS_EN cycle with TP = n < 12, TP SHALL become n+1 on the next edge.
REQ-020 On a PHS_EN cycle with TP = 12 and MSTOP = 0, TP SHALL wrap to 1 (MCT boundary).
REQ-021 On a PHS_EN cycle with TP = 12 and MSTOP = 1, TP SHALL hold at 12, with no boundary transfer and no MCTEND.
REQ-022 MSTOP SHALL have no effect while TP is not 12.
REQ-023 Without PHS_EN, TP, stage and outputs SHALL hold. Pending bits still accept requests (REQ-024).
REQ-024 A 2-bit pending register PEND SHALL OR in ST1REQ into bit 0 and ST2REQ into bit 1 on every cycle.
REQ-025 On an MCT boundary cycle, stage SHALL load {PEND[1] | ST2REQ, PEND[0] | ST1REQ}, and PEND SHALL clear to 0.
REQ-026 Consequently, a request asserted on the boundary cycle itself SHALL apply to the MCT starting at that boundary. It SHALL NOT be retained for the following MCT.
REQ-027 MCTEND SHALL be registered and high for exactly the one cycle after each boundary edge, coincident with TP = 1.
REQ-028 Stage decodes SHALL be combinational from the stage register:
  - ST0_n/ST1_n/ST3_n low and STD2 high for stage values 0/1/3/2 respectively;
  - exactly one stage decode is active at any time.
REQ-029 Timepulse decodes SHALL be combinational from TP. At most one of T01_n low, T02 high, T12_n low SHALL be active at a time.
REQ-030 GOJAM = 1 SHALL, on the next edge, clear stage to 0 and PEND to 0, overriding ST1REQ/ST2REQ and any simultaneous boundary transfer. TP SHALL still advance per REQ-019..021.
REQ-031 On a boundary cycle with GOJAM = 1, MCTEND SHALL still pulse.
REQ-032 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-033 While SIM_RST = 1, the block SHALL force TP = 1, stage = 0, PEND = 0, MCTEND = 0, independent of SIM_CLK.
REQ-034 After reset, outputs SHALL be T01_n = 0, T02 = 0, T12_n = 1, ST0_n = 0, ST1_n = 1, STD2 = 0, ST3_n = 1, MCTEND = 0.
REQ-035 Reset asserted mid-MCT SHALL discard pending requests. The first boundary after release SHALL occur after 12 PHS_EN strobes.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - Reset, then 24 PHS_EN strobes with no requests -> TP runs 1..12,1..12; MCTEND pulses twice; ST0_n stays 0.
  - ST1REQ pulsed at TP = 5 -> after the next boundary, ST1_n = 0 for one MCT, then ST0_n = 0.
  - ST1REQ at TP = 3 and ST2REQ at TP = 9 -> next MCT has ST3_n = 0.
  - ST2REQ only on the boundary cycle -> STD2 = 1 in the new MCT and 0 in the MCT after.
  - MSTOP = 1 at TP = 12 for 5 strobes -> TP stays 12, no MCTEND, stage unchanged; release -> wrap to 1 with transfer.
  - GOJAM on a boundary cycle with PEND = 2'b11 -> stage = 0, PEND = 0, TP = 1, MCTEND = 1.
  - SIM_RST pulsed between clock edges at TP = 7 with stage 2 -> immediate TP = 1 and ST0_n = 0.

Source files
------------

// File: rtl/stage_timing.sv
// stage_timing: timepulse sequencer (TP 1..12) with MCT-boundary stage transfer.
//   Inputs : SIM_CLK clock, SIM_RST async active-high reset, PHS_EN timepulse
//            advance strobe, MSTOP monitor stop (holds at T12), GOJAM restart,
//            ST1REQ/ST2REQ stage bit requests for the next MCT.
//   Outputs: T01_n/T02/T12_n timepulse decodes, TP current timepulse,
//            ST0_n/ST1_n/STD2/ST3_n stage decodes, MCTEND boundary pulse.
// Every output is taken from registered state, so no input reaches an output
// without passing through a flop.
module stage_timing (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       PHS_EN,
  input  logic       MSTOP,
  input  logic       GOJAM,
  input  logic       ST1REQ,
  input  logic       ST2REQ,
  output logic       T01_n,
  output logic       T02,
  output logic       T12_n,
  output logic [3:0] TP,
  output logic       ST0_n,
  output logic       ST1_n,
  output logic       STD2,
  output logic       ST3_n,
  output logic       MCTEND
);

  localparam int unsigned TP_W    = 4;
  localparam int unsigned ST_W    = 2;
  localparam int unsigned TP_LAST = 12;

  logic [TP_W-1:0] tp_q;
  logic [ST_W-1:0] stage_q;
  logic [ST_W-1:0] pend_q;
  logic            mctend_q;
  logic            at_last;
  logic            boundary;
  logic [ST_W-1:0] req;

  assign at_last  = (tp_q == TP_W'(TP_LAST));
  // MCT boundary: strobe at T12 without monitor stop.
  assign boundary = PHS_EN && at_last && !MSTOP;
  assign req      = {ST2REQ, ST1REQ};

  // Timepulse counter, stage/pending registers and boundary pulse.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      tp_q     <= TP_W'(1);
      stage_q  <= '0;
      pend_q   <= '0;
      mctend_q <= 1'b0;
    end else begin
      if (PHS_EN) begin
        if (!at_last) begin
          tp_q <= tp_q + TP_W'(1);
        end else if (!MSTOP) begin
          tp_q <= TP_W'(1);
        end
      end
      // MCTEND follows every boundary, GOJAM included.
      mctend_q <= boundary;
      // GOJAM wins over both request capture and boundary transfer; a request
      // on the boundary cycle goes straight into the new stage, not into PEND.
      if (GOJAM) begin
        stage_q <= '0;
        pend_q  <= '0;
      end else if (boundary) begin
        stage_q <= pend_q | req;
        pend_q  <= '0;
      end else begin
        pend_q  <= pend_q | req;
      end
    end
  end

  // Decodes of registered state.
  assign TP     = tp_q;
  assign T01_n  = (tp_q != TP_W'(1));
  assign T02    = (tp_q == TP_W'(2));
  assign T12_n  = !at_last;
  assign ST0_n  = (stage_q != ST_W'(0));
  assign ST1_n  = (stage_q != ST_W'(1));
  assign STD2   = (stage_q == ST_W'(2));
  assign ST3_n  = (stage_q != ST_W'(3));
  assign MCTEND = mctend_q;

endmodule

// File: tb/tb_stage_timing.sv
// tb_stage_timing: directed scenarios plus randomized run checked against a
// behavioural model of timepulse, stage and pending-request rules.
module tb_stage_timing;

  logic       SIM_CLK;
  logic       SIM_RST;
  logic       PHS_EN, MSTOP, GOJAM, ST1REQ, ST2REQ;
  logic       T01_n, T02, T12_n;
  logic [3:0] TP;
  logic       ST0_n, ST1_n, STD2, ST3_n, MCTEND;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_tp    = 1;
  int m_stage = 0;
  int m_pend  = 0;
  bit m_mct   = 0;

  stage_timing dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .PHS_EN(PHS_EN), .MSTOP(MSTOP),
    .GOJAM(GOJAM), .ST1REQ(ST1REQ), .ST2REQ(ST2REQ),
    .T01_n(T01_n), .T02(T02), .T12_n(T12_n), .TP(TP),
    .ST0_n(ST0_n), .ST1_n(ST1_n), .STD2(STD2), .ST3_n(ST3_n), .MCTEND(MCTEND)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  // Drive one clock cycle of inputs, advance the model, sample 1 ns after edge.
  task automatic cycle(input bit p, input bit m, input bit g, input bit r1, input bit r2);
    bit bnd;
    int rq;
    PHS_EN = p; MSTOP = m; GOJAM = g; ST1REQ = r1; ST2REQ = r2;
    @(posedge SIM_CLK);
    rq  = (r2 ? 2 : 0) + (r1 ? 1 : 0);
    bnd = p && (m_tp == 12) && !m;
    m_mct = bnd;
    if (g) begin
      m_stage = 0; m_pend = 0;
    end else if (bnd) begin
      m_stage = m_pend | rq; m_pend = 0;
    end else begin
      m_pend = m_pend | rq;
    end
    if (p && !(m_tp == 12 && m)) m_tp = (m_tp % 12) + 1;
    #1;
    PHS_EN = 0; MSTOP = 0; GOJAM = 0; ST1REQ = 0; ST2REQ = 0;
  endtask

  task automatic goto_tp(input int n);
    for (int i = 0; i < 30 && m_tp != n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) cycle(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset;
    SIM_RST = 1;
    m_tp = 1; m_stage = 0; m_pend = 0; m_mct = 0;
    repeat (2) @(posedge SIM_CLK);
    #1;
    checks++;
    if ({T01_n, T02, T12_n, ST0_n, ST1_n, STD2, ST3_n, MCTEND} !== 8'b0010_1010) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {T01_n, T02, T12_n, ST0_n, ST1_n, STD2, ST3_n, MCTEND}, 8'b0010_1010);
    end
    checks++;
    if (TP !== 4'd1) begin errors++; $display("FAIL reset_tp: got %0d want 1", TP); end
    @(negedge SIM_CLK);
    SIM_RST = 0;
    @(posedge SIM_CLK); #1;
  endtask

  task automatic test_free_run;
    int pulses = 0;
    bit st0_ok = 1;
    for (int k = 1; k <= 24; k++) begin
      cycle(1, 0, 0, 0, 0);
      if (MCTEND === 1'b1) pulses++;
      if (ST0_n !== 1'b0) st0_ok = 0;
      checks++;
      if (TP !== 4'((k % 12) + 1)) begin
        errors++;
        $display("FAIL free_run_tp: strobe %0d got %0d want %0d", k, TP, (k % 12) + 1);
      end
      if ($urandom_range(0, 2) == 0) begin
        cycle(0, 0, 0, 0, 0);
        if (MCTEND === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL free_run_mctend: got %0d pulses want 2", pulses); end
    checks++;
    if (!st0_ok) begin errors++; $display("FAIL free_run_st0: ST0_n left 0 got 1 want 0"); end
  endtask

  task automatic test_st1;
    goto_tp(5);
    cycle(0, 0, 0, 1, 0);
    goto_tp(12);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if ({ST0_n, ST1_n, MCTEND} !== 3'b101) begin
      errors++; $display("FAIL st1_stage: got ST0_n/ST1_n/MCTEND=%b want 101", {ST0_n, ST1_n, MCTEND});
    end
    strobes(12);
    checks++;
    if ({ST0_n, ST1_n} !== 2'b01) begin
      errors++; $display("FAIL st1_next_mct: got ST0_n/ST1_n=%b want 01", {ST0_n, ST1_n});
    end
  endtask

  task automatic test_st3;
    goto_tp(3);
    cycle(1, 0, 0, 1, 0);
    goto_tp(9);
    cycle(0, 0, 0, 0, 1);
    goto_tp(1);
    checks++;
    if ({ST3_n, STD2, ST1_n, ST0_n} !== 4'b0011) begin
      errors++; $display("FAIL st3_stage: got ST3_n/STD2/ST1_n/ST0_n=%b want 0011", {ST3_n, STD2, ST1_n, ST0_n});
    end
  endtask

  task automatic test_boundary_req;
    goto_tp(12);
    cycle(1, 0, 0, 0, 1);
    checks++;
    if ({STD2, TP} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL bnd_req_new: got STD2=%b TP=%0d want STD2=1 TP=1", STD2, TP);
    end
    goto_tp(12);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if ({STD2, ST0_n} !== 2'b00) begin
      errors++; $display("FAIL bnd_req_after: got STD2/ST0_n=%b want 00", {STD2, ST0_n});
    end
  endtask

  task automatic test_mstop;
    bit hold_ok = 1;
    goto_tp(12);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, (i == 2), 0);
      if (TP !== 4'd12 || MCTEND !== 1'b0 || ST0_n !== 1'b0 || T12_n !== 1'b0) hold_ok = 0;
      cycle(0, 1, 0, 0, 0);
    end
    checks++;
    if (!hold_ok) begin errors++; $display("FAIL mstop_hold: got TP=%0d MCTEND=%b want TP=12 MCTEND=0", TP, MCTEND); end
    cycle(1, 0, 0, 0, 0);
    checks++;
    if ({TP, MCTEND, ST1_n} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mstop_release: got TP=%0d MCTEND=%b ST1_n=%b want 1 1 0", TP, MCTEND, ST1_n);
    end
    checks++;
    cycle(0, 0, 0, 0, 0);
    if (MCTEND !== 1'b0) begin errors++; $display("FAIL mctend_width: got %b want 0", MCTEND); end
  endtask

  task automatic test_gojam;
    goto_tp(11);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 1, 1);
    checks++;
    if ({TP, MCTEND, ST0_n} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL gojam_boundary: got TP=%0d MCTEND=%b ST0_n=%b want 1 1 0", TP, MCTEND, ST0_n);
    end
    goto_tp(12);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (ST0_n !== 1'b0) begin errors++; $display("FAIL gojam_pend: got ST0_n=%b want 0", ST0_n); end
  endtask

  task automatic test_async_reset;
    int first = 0;
    goto_tp(12);
    cycle(1, 0, 0, 0, 1);
    goto_tp(7);
    cycle(0, 0, 0, 1, 0);
    #2 SIM_RST = 1;
    #1;
    checks++;
    if ({TP, ST0_n, STD2} !== {4'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset: got TP=%0d ST0_n=%b STD2=%b want 1 0 0", TP, ST0_n, STD2);
    end
    #1 SIM_RST = 0;
    m_tp = 1; m_stage = 0; m_pend = 0; m_mct = 0;
    for (int k = 1; k <= 12 && first == 0; k++) begin
      cycle(1, 0, 0, 0, 0);
      if (MCTEND === 1'b1) first = k;
    end
    checks++;
    if (first != 12) begin errors++; $display("FAIL reset_first_boundary: got strobe %0d want 12", first); end
    checks++;
    if (ST0_n !== 1'b0) begin errors++; $display("FAIL reset_discard_pend: got ST0_n=%b want 0", ST0_n); end
  endtask

  task automatic test_random;
    logic [11:0] got, exp;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 12) == 0, $urandom_range(0, 12) == 0);
      got = {T01_n, T02, T12_n, TP, ST0_n, ST1_n, STD2, ST3_n, MCTEND};
      exp = {m_tp != 1, m_tp == 2, m_tp != 12, 4'(m_tp),
             m_stage != 0, m_stage != 1, m_stage == 2, m_stage != 3, m_mct};
      checks++;
      if (got !== exp) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle %0d: got %b want %b", i, got, exp);
        bad++;
      end
    end
  endtask

  initial begin
    PHS_EN = 0; MSTOP = 0; GOJAM = 0; ST1REQ = 0; ST2REQ = 0; SIM_RST = 0;
    #2;
    test_reset;
    test_free_run;
    test_st1;
    test_st3;
    test_boundary_req;
    test_mstop;
    test_gojam;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
